// File: rtl/player_ctl.sv
// Player movement controller.
// Once per frame, on the rising edge of vertical blanking, it samples the
// direction/jump buttons, advances a walk/jump/fall state machine and updates
// the registered position and pose that the player draw stage reads during
// the active region.

module player_ctl #(
  parameter int X_START   = 1,
  parameter int X_MIN     = 1,
  parameter int X_MAX     = 997,
  parameter int GROUND_Y  = 420,
  parameter int WALK_STEP = 4,
  parameter int JUMP_V0   = 12,
  parameter int GRAVITY   = 1,
  parameter int MAX_FALL  = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vblnk_in,
  input  logic        enable,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_jump,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        facing,
  output logic [1:0]  pose
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    JUMP = 2'd2,
    FALL = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  logic [4:0]  vel_q, vel_d;
  logic        facing_q, facing_d;
  logic        vblnk_d;

  logic        tick;
  logic        upd;
  logic        go_left;
  logic        go_right;
  logic        one_dir;

  // Horizontal and vertical arithmetic is done one bit wider than the outputs
  // so that saturation can be decided before truncating.
  logic [12:0] x_inc;
  logic [12:0] x_dec;
  logic [12:0] y_jump;
  logic [4:0]  vel_jump;
  logic [5:0]  vel_sum;
  logic [4:0]  vel_fall;
  logic [12:0] y_fall;
  logic        land;

  // Frame tick: one clk wide, on the cycle where vblnk_in first goes high.
  assign tick     = vblnk_in & ~vblnk_d;
  assign upd      = tick & enable;
  assign go_left  = btn_left & ~btn_right;
  assign go_right = btn_right & ~btn_left;
  assign one_dir  = btn_left ^ btn_right;

  // Delay vblnk_in by one clk for edge detection; runs even when disabled so
  // re-enabling mid-blank does not fabricate a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_d <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      vblnk_d <= vblnk_in;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Trajectory arithmetic shared by the next-state and datapath logic.
  always_comb begin
    x_inc    = {1'b0, x_q} + 13'(WALK_STEP);
    x_dec    = {1'b0, x_q} - 13'(WALK_STEP);
    y_jump   = {1'b0, y_q} - {8'd0, vel_q};
    vel_jump = vel_q - 5'(GRAVITY);
    vel_sum  = {1'b0, vel_q} + 6'(GRAVITY);
    vel_fall = (vel_sum > 6'(MAX_FALL)) ? 5'(MAX_FALL) : vel_sum[4:0];
    y_fall   = {1'b0, y_q} + {8'd0, vel_fall};
    land     = (y_fall >= 13'(GROUND_Y));
  end

  // Next-state logic: only moves on an enabled frame tick.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    if (upd) begin
      unique case (state_q)
        IDLE, WALK: begin
          if (btn_jump)     state_d = JUMP;
          else if (one_dir) state_d = WALK;
          else              state_d = IDLE;
        end
        JUMP: begin
          if (vel_jump == 5'd0) state_d = FALL;
        end
        FALL: begin
          if (land) state_d = one_dir ? WALK : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath next values: horizontal move in every state, vertical per state.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    vel_d    = vel_q;
    facing_d = facing_q;
    if (upd) begin
      if (go_right) begin
        facing_d = 1'b1;
        x_d      = (x_inc > 13'(X_MAX)) ? 12'(X_MAX) : x_inc[11:0];
      end else if (go_left) begin
        facing_d = 1'b0;
        x_d      = ({1'b0, x_q} < 13'(X_MIN + WALK_STEP)) ? 12'(X_MIN) : x_dec[11:0];
      end

      unique case (state_q)
        IDLE, WALK: begin
          if (btn_jump) vel_d = 5'(JUMP_V0);
        end
        JUMP: begin
          // Underflow guard: stop at the top of the screen.
          y_d   = y_jump[12] ? 12'd0 : y_jump[11:0];
          vel_d = vel_jump;
        end
        FALL: begin
          if (land) begin
            y_d   = 12'(GROUND_Y);
            vel_d = 5'd0;
          end else begin
            y_d   = y_fall[11:0];
            vel_d = vel_fall;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers; reset puts the player back on the ground.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= 12'(X_START);
      y_q      <= 12'(GROUND_Y);
      vel_q    <= 5'd0;
      facing_q <= 1'b1;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      vel_q    <= vel_d;
      facing_q <= facing_d;
    end
  end

  // Output decode: pose is the current state, position is registered.
  always_comb begin
    pose   = state_q;
    xpos   = x_q;
    ypos   = y_q;
    facing = facing_q;
  end

endmodule

// File: tb/tb_player_ctl.sv
// Directed testbench for player_ctl with hand-computed expected values.

module tb_player_ctl;

  logic        clk;
  logic        rst_n;
  logic        vblnk_in;
  logic        enable;
  logic        btn_left;
  logic        btn_right;
  logic        btn_jump;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        facing;
  logic [1:0]  pose;

  int n_checks = 0;
  int n_errors = 0;

  // ypos after each tick following the jump tick (default parameters).
  int y_tab [24] = '{408, 397, 387, 378, 370, 363, 357, 352, 348, 345, 343, 342,
                     343, 345, 348, 352, 357, 363, 370, 378, 387, 397, 408, 420};

  player_ctl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vblnk_in  (vblnk_in),
    .enable    (enable),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_jump  (btn_jump),
    .xpos      (xpos),
    .ypos      (ypos),
    .facing    (facing),
    .pose      (pose)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One video frame: blanking high for 3 clks, then low for 3 clks.
  // Inputs are changed only at posedge+1, outputs sampled there too.
  task automatic frame();
    vblnk_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vblnk_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input logic l, input logic r, input logic j);
    btn_left  = l;
    btn_right = r;
    btn_jump  = j;
  endtask

  initial begin
    rst_n    = 1'b0;
    vblnk_in = 1'b0;
    enable   = 1'b1;
    set_btn(1'b0, 1'b0, 1'b0);

    // Reset asserted mid-frame, released with blanking low.
    repeat (2) @(posedge clk);
    #1 vblnk_in = 1'b1;
    repeat (2) @(posedge clk);
    #1 vblnk_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_x", xpos, 1);
    check("rst_y", ypos, 420);
    check("rst_facing", facing, 1);
    check("rst_pose", pose, 0);

    // Button pressed and released between ticks: no effect.
    set_btn(1'b0, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("no_tick_x", xpos, 1);
    check("no_tick_pose", pose, 0);
    set_btn(1'b0, 1'b0, 1'b0);
    frame();
    check("short_press_x", xpos, 1);

    // Walk right 10 frames; first update visible 1 clk after vblnk rises.
    set_btn(1'b0, 1'b1, 1'b0);
    vblnk_in = 1'b1;
    @(posedge clk);
    #1;
    check("latency_x", xpos, 5);
    repeat (2) @(posedge clk);
    #1 vblnk_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) frame();
    check("walk_x", xpos, 41);
    check("walk_pose", pose, 1);
    check("walk_facing", facing, 1);
    set_btn(1'b0, 1'b0, 1'b0);
    frame();
    check("release_pose", pose, 0);
    check("release_x", xpos, 41);

    // Both directions: no movement, idle.
    set_btn(1'b1, 1'b1, 1'b0);
    frame();
    check("both_x", xpos, 41);
    check("both_pose", pose, 0);
    check("both_facing", facing, 1);

    // Left clamp at X_MIN.
    set_btn(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) frame();
    check("left_x", xpos, 1);
    check("left_facing", facing, 0);
    frame();
    check("left_clamp_x", xpos, 1);
    check("left_clamp_facing", facing, 0);

    // Right clamp at X_MAX: 249 steps reach 997 exactly, then saturate.
    set_btn(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 249; i++) frame();
    check("right_x", xpos, 997);
    frame();
    check("right_clamp_x", xpos, 997);
    check("right_clamp_facing", facing, 1);
    set_btn(1'b1, 1'b0, 1'b0);
    frame();
    check("right_back_x", xpos, 993);
    set_btn(1'b0, 1'b1, 1'b0);
    frame();
    check("right_reclamp_x", xpos, 997);
    set_btn(1'b0, 1'b0, 1'b0);
    frame();
    check("idle_again_pose", pose, 0);

    // Plain jump, jump pressed again mid-flight is ignored.
    set_btn(1'b0, 1'b0, 1'b1);
    frame();
    check("jump_pose", pose, 2);
    check("jump_y0", ypos, 420);
    for (int i = 0; i < 24; i++) begin
      set_btn(1'b0, 1'b0, (i == 4) || (i == 15));
      frame();
      check($sformatf("jump_y%0d", i + 1), ypos, y_tab[i]);
      check($sformatf("jump_pose%0d", i + 1), pose, (i < 11) ? 2 : ((i < 23) ? 3 : 0));
    end
    check("jump_land_x", xpos, 997);

    // Jump with right held: 4 px per frame all through the flight.
    set_btn(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) frame();
    check("pre_jr_x", xpos, 837);
    set_btn(1'b0, 1'b1, 1'b1);
    frame();
    check("jr_pose", pose, 2);
    check("jr_x0", xpos, 841);
    set_btn(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) frame();
    check("jr_apex_x", xpos, 889);
    check("jr_apex_y", ypos, 342);
    for (int i = 0; i < 12; i++) frame();
    check("jr_land_x", xpos, 937);
    check("jr_land_y", ypos, 420);
    check("jr_land_pose", pose, 1);

    // Jump held continuously: re-enters JUMP on the tick after landing.
    set_btn(1'b0, 1'b0, 1'b1);
    frame();
    check("hold_pose", pose, 2);
    for (int i = 0; i < 24; i++) frame();
    check("hold_land_pose", pose, 0);
    check("hold_land_y", ypos, 420);
    frame();
    check("hold_rejump_pose", pose, 2);

    // Freeze mid-flight with enable low.
    set_btn(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) frame();
    check("pre_freeze_y", ypos, 370);
    enable = 1'b0;
    set_btn(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) frame();
    check("freeze_y", ypos, 370);
    check("freeze_x", xpos, 937);
    check("freeze_pose", pose, 2);
    check("freeze_facing", facing, 1);
    set_btn(1'b0, 1'b0, 1'b0);
    enable = 1'b1;
    for (int i = 0; i < 18; i++) frame();
    check("resume_y", ypos, 408);
    check("resume_pose", pose, 3);
    frame();
    check("resume_land_y", ypos, 420);
    check("resume_land_pose", pose, 0);

    // Async reset mid-flight returns straight to the ground.
    set_btn(1'b0, 1'b0, 1'b1);
    frame();
    set_btn(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) frame();
    check("pre_rst_y", ypos, 387);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_y", ypos, 420);
    check("midrst_pose", pose, 0);
    check("midrst_x", xpos, 1);
    check("midrst_facing", facing, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/player_ctl.md
Name: player_ctl

Overview:
Frame-synchronous player movement controller: the sequencer that owns player position for the background/sprite drawing datapath. Once per frame, at the start of vertical blanking, it samples the directional/jump inputs, runs a walk/jump/fall state machine and updates registered position and pose outputs. The player draw stage consumes these outputs and only reads them during the active region, so updates never tear.

Parameters:
X_START, 1, xpos after reset (left edge of player body)
X_MIN, 1, minimum xpos (inside left border line)
X_MAX, 997, maximum xpos (1024 - 2 - player width 25)
GROUND_Y, 420, ypos when standing (top of 80 px body on ground at 500)
WALK_STEP, 4, horizontal pixels moved per frame
JUMP_V0, 12, initial upward velocity, px/frame
GRAVITY, 1, velocity change per frame
MAX_FALL, 15, falling velocity cap, px/frame

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous reset, active-low
vblnk_in  in  1  vertical blanking from VGA timing chain
enable  in  1  game running; 0 freezes all state
btn_left  in  1  move left (already synchronised/debounced)
btn_right  in  1  move right
btn_jump  in  1  jump request
xpos  out  12  player left edge
ypos  out  12  player top edge
facing  out  1  1 = right, 0 = left
pose  out  2  0 IDLE, 1 WALK, 2 JUMP, 3 FALL (current FSM state)

Behaviour:
- Reset (rst_n low, async): xpos=X_START, ypos=GROUND_Y, facing=1, pose=IDLE, velocity=0, vblnk_d=0. Reset mid-jump returns directly to ground.
- tick = vblnk_in & ~vblnk_d (vblnk_d registered each clk). All state updates occur on the clk edge where tick=1 and enable=1; outputs change 1 clk after vblnk_in rises. No update on any other cycle.
- Inputs are sampled only on the tick cycle; presses shorter than a frame between ticks are ignored.
- Horizontal, in every state: exactly one of left/right asserted -> xpos +/- WALK_STEP, saturated to [X_MIN, X_MAX]; facing set to that direction even when clamped. Both or neither -> xpos and facing unchanged.
- Internal velocity: 5-bit unsigned; ypos arithmetic done 13-bit, result clamped to GROUND_Y.
- IDLE/WALK (grounded): btn_jump -> JUMP, vel=JUMP_V0, ypos unchanged this tick. Else state = WALK if exactly one direction pressed, IDLE otherwise.
- JUMP: ypos <= ypos - vel; vel <= vel - GRAVITY; when new vel = 0 -> FALL.
- FALL: v = min(vel + GRAVITY, MAX_FALL); if ypos + v >= GROUND_Y -> ypos=GROUND_Y, vel=0, state WALK/IDLE per direction inputs on that tick; else ypos += v, vel=v.
- btn_jump ignored while airborne; no jump buffering. Jump held through landing tick -> new jump starts on the following tick.
- enable=0: tick ignored, all outputs hold; resuming continues from held state and velocity.
- With defaults: apex ypos=342 after 12 ticks, landing 12 ticks later (24 ticks total).

Test Plan:
- Reset: hold rst_n=0 mid-frame, release -> xpos=1, ypos=420, facing=1, pose=0; no change until first vblnk_in rising edge.
- Walk: btn_right held 10 frames from reset -> xpos=41, pose=1, facing=1; release -> pose=0 next tick, xpos=41.
- Left clamp: xpos=3, btn_left one frame -> xpos=1, facing=0; further frames keep 1. Right clamp: from 995, right -> 997.
- Jump: btn_jump pulse on one tick -> pose=2; after 12 ticks ypos=342, pose=3; after 24 ticks ypos=420, pose=0. btn_jump during flight ignored.
- Jump + right held: xpos advances 4/frame throughout flight, lands pose=1; jump held continuously re-enters pose=2 on tick after landing.
- enable=0 for 5 frames mid-jump -> outputs frozen; after re-enable trajectory resumes and total flight stays 24 active ticks; rst_n low mid-flight -> immediate ypos=420, pose=0.
